ecc_57_err_collect: RTL
=======================

# ecc_57_err_collect

Downstream stage of the 57-bit ECC fault detector in the FIFO read path. Registers each checked word (corrected data plus error flags) into a 2-entry valid/ready output buffer, keeps saturating error counters and a first-error capture record, and raises a sticky interrupt. The ECC check stays purely combinational; this block adds the only sequential state on the read side.

## Interface
- DATA_WIDTH, 57, data word width (matches detector output)
- ADDR_WIDTH, 8, RAM address tag width
- CNT_WIDTH, 8, error counter width
- SBIT_THR, 16, single-bit count at which irq fires (1..2^CNT_WIDTH-1)

- clk  in  1  clock, all state rising-edge
- rst  in  1  synchronous, active-high reset
- in_vld  in  1  checked word present
- in_rdy  out  1  buffer can accept
- in_data  in  DATA_WIDTH  corrected data from detector
- in_addr  in  ADDR_WIDTH  RAM address of the word
- in_sbit_err / in_dbit_err / in_ecc_fault  in  1 each  detector flags
- out_vld  out  1  buffered word available
- out_rdy  in  1  consumer accepts
- out_data  out  DATA_WIDTH  buffered data
- out_poison  out  1  word carries dbit error or ecc fault
- cnt_clr  in  1  clears counters, capture record, irq
- sbit_cnt / dbit_cnt / fault_cnt  out  CNT_WIDTH each  saturating counts
- err_addr  out  ADDR_WIDTH  address of first error since clear
- err_type  out  2  00 none, 01 sbit, 10 dbit, 11 fault
- err_vld  out  1  capture record valid
- irq  out  1  sticky interrupt

## Operation
- Accept: in_vld & in_rdy. Pop: out_vld & out_rdy.
- Buffer: 2-entry FIFO, entries {data, poison}; poison = in_dbit_err | in_ecc_fault. in_rdy = (count < 2), from registered count only. out_vld = (count != 0); out_data/out_poison = head entry.
- Count: +1 on accept-only, -1 on pop-only, unchanged on both or neither. Push and pop in same cycle allowed at count 1 (and at 2 only the pop occurs, in_rdy=0).
- Counters: each increments on an accepted beat whose flag is set; flags counted independently (fault and dbit on same beat bump both). Saturate at 2^CNT_WIDTH-1, never wrap.
- cnt_clr: counters go to 0, except an increment event in the same cycle yields 1 (clear then count).
- Capture: on accepted beat with any flag while err_vld=0, load err_addr=in_addr, err_type by priority fault > dbit > sbit, err_vld=1. Held until cnt_clr. cnt_clr coincident with an error beat: new beat is captured (err_vld stays 1).
- irq: set when an accepted beat has dbit or fault, or when sbit_cnt's next value equals SBIT_THR. Cleared only by cnt_clr; set condition in the clear cycle wins.
- Flags on non-accepted cycles are ignored.

## Timing
- Reset values: in_rdy=1 in the cycle after rst deasserts (0 only while count=2), out_vld=0, out_data=0, out_poison=0, all counters 0, err_addr=0, err_type=00, err_vld=0, irq=0; buffer count 0.
- rst mid-operation discards buffered words; no pop occurs in reset cycle.
- Latency: accepted word visible on out_vld/out_data the next cycle (empty buffer).
- Counters, err_*, irq update on the edge following the accept; visible next cycle.
- Throughput: 1 word/cycle sustained with out_rdy=1; with out_rdy=0, 2 words absorbed then in_rdy=0 the following cycle.
- out_data stable while out_vld=1 and out_rdy=0.

## Test plan
- Stream 10 clean words (addr 0..9), out_rdy=1 -> each appears 1 cycle later in order, poison=0, all counts 0, err_vld=0, irq=0.
- out_rdy=0, push 3 words -> 2 accepted, in_rdy=0 after 2nd; out_rdy=1 -> drains in order, in_rdy returns.
- sbit beat at addr 0x12 then dbit at 0x34 -> err_addr=0x12, err_type=01, sbit_cnt=1, dbit_cnt=1, irq=1 after dbit beat, second word out_poison=1.
- 300 sbit beats, CNT_WIDTH=8, SBIT_THR=16 -> irq rises on 16th beat, sbit_cnt saturates at 255.
- cnt_clr same cycle as fault beat at addr 0x05 -> fault_cnt=1, err_type=11, err_addr=0x05, irq=1.
- rst asserted with 2 words buffered -> out_vld=0 next cycle, counters/irq 0, in_rdy=1.

Source files
------------

// File: rtl/ecc_57_err_collect_if.sv
// Read-side handshake bundle between the ECC detector, the collector and its consumer.
// The slave modport is the collector's view; master is the producer/consumer side.
interface ecc_57_err_collect_if #(
  parameter int DATA_WIDTH = 57,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_sbit_err;
  logic                  in_dbit_err;
  logic                  in_ecc_fault;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_poison;

  modport slave (
    input  in_vld, in_data, in_addr, in_sbit_err, in_dbit_err, in_ecc_fault, out_rdy,
    output in_rdy, out_vld, out_data, out_poison
  );

  modport master (
    output in_vld, in_data, in_addr, in_sbit_err, in_dbit_err, in_ecc_fault, out_rdy,
    input  in_rdy, out_vld, out_data, out_poison
  );
endinterface

// File: rtl/ecc_57_err_collect.sv
// ECC error collector: 2-entry output buffer, saturating error counters, first-error capture, sticky irq.
// Latency 1 cycle to out_vld; in_rdy drops only when both entries are full (registered count).
module ecc_57_err_collect #(
  parameter int DATA_WIDTH = 57,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int SBIT_THR   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_57_err_collect_if.slave   bus,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [1:0]            err_type,
  output logic                  err_vld,
  output logic                  irq
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  poison;
  } entry_t;

  entry_t     mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       accept;
  logic       pop;
  logic       any_err;

  assign bus.in_rdy     = (count < 2'd2);
  assign bus.out_vld    = (count != 2'd0);
  assign bus.out_data   = mem[rd_ptr].data;
  assign bus.out_poison = mem[rd_ptr].poison;

  assign accept  = bus.in_vld & bus.in_rdy;
  assign pop     = bus.out_vld & bus.out_rdy;
  assign any_err = bus.in_sbit_err | bus.in_dbit_err | bus.in_ecc_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= '{data: bus.in_data, poison: bus.in_dbit_err | bus.in_ecc_fault};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Clear is applied before the increment, so a coincident event leaves the count at 1.
  function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic inc, input logic clr);
    logic [CNT_WIDTH-1:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != '1)) base = base + CNT_WIDTH'(1);
    return base;
  endfunction

  logic [CNT_WIDTH-1:0] sbit_nxt, dbit_nxt, fault_nxt;
  logic                 sbit_inc, dbit_inc, fault_inc;
  logic                 irq_set;
  logic [1:0]           type_nxt;

  always_comb begin
    sbit_inc  = accept & bus.in_sbit_err;
    dbit_inc  = accept & bus.in_dbit_err;
    fault_inc = accept & bus.in_ecc_fault;
    sbit_nxt  = sat_next(sbit_cnt, sbit_inc, cnt_clr);
    dbit_nxt  = sat_next(dbit_cnt, dbit_inc, cnt_clr);
    fault_nxt = sat_next(fault_cnt, fault_inc, cnt_clr);
    irq_set   = dbit_inc | fault_inc | (sbit_inc & (sbit_nxt == CNT_WIDTH'(SBIT_THR)));
    type_nxt  = bus.in_ecc_fault ? 2'b11 : (bus.in_dbit_err ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      fault_cnt <= '0;
      err_addr  <= '0;
      err_type  <= 2'b00;
      err_vld   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      sbit_cnt  <= sbit_nxt;
      dbit_cnt  <= dbit_nxt;
      fault_cnt <= fault_nxt;
      if (accept && any_err && (!err_vld || cnt_clr)) begin
        err_addr <= bus.in_addr;
        err_type <= type_nxt;
        err_vld  <= 1'b1;
      end else if (cnt_clr) begin
        err_addr <= '0;
        err_type <= 2'b00;
        err_vld  <= 1'b0;
      end
      if (irq_set)      irq <= 1'b1;
      else if (cnt_clr) irq <= 1'b0;
    end
  end

endmodule
